// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit bundle between the TX arbiter, its response sources and uart_tx.
// slave = arbiter side, master = sources plus the uart_tx busy flag.
interface uart_tx_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic [NUM_CH-1:0]        req_last;
  logic [NUM_CH-1:0]        req_ready;
  logic [DATA_W-1:0]        tx_data;
  logic                     tx_send;
  logic                     tx_busy;
  logic [CH_W-1:0]          grant_ch;
  logic                     lock_active;
  logic                     timeout_err;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_send, grant_ch, lock_active, timeout_err
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_send, grant_ch, lock_active, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locking round-robin arbiter feeding one uart_tx from NUM_CH sources.
// Define TX_ARB_TIMEOUT_EN to build the stalled-owner release counter.
module uart_tx_arbiter #(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOCK, S_SEND, S_WAIT_START, S_WAIT_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              lock_q, lock_d;
  logic              last_q, last_d;
  logic              send_q, send_d;
  logic              ws_cnt_q, ws_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
`ifdef TX_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              to_err_q, to_err_d;
`endif

  logic              hit;
  logic [CH_W-1:0]   hit_idx;
  logic              accept;
  logic [CH_W-1:0]   next_ptr;
  logic [NUM_CH-1:0] ready;

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  // First requester at or after rr_ptr, wrapping past the top channel.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!hit && bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
        hit     = 1'b1;
        hit_idx = wrap_add(rr_ptr_q, k);
      end
    end
  end

  assign next_ptr = wrap_add(grant_q, 1);
  assign accept   = (state_q == S_LOCK) && bus.req_valid[grant_q] && !bus.tx_busy;

  always_comb begin
    ready          = '0;
    ready[grant_q] = accept;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    last_d   = last_q;
    data_d   = data_q;
    send_d   = 1'b0;
    ws_cnt_d = ws_cnt_q;
`ifdef TX_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    to_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef TX_ARB_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        if (hit) begin
          grant_d = hit_idx;
          lock_d  = 1'b1;
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        if (accept) begin
          data_d  = bus.req_data[grant_q*DATA_W +: DATA_W];
          last_d  = bus.req_last[grant_q];
          send_d  = 1'b1;
          state_d = S_SEND;
`ifdef TX_ARB_TIMEOUT_EN
          to_cnt_d = '0;
        end else if (!bus.req_valid[grant_q]) begin
          // Owner went quiet mid-packet: count its silence, evict at the limit.
          if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            to_err_d = 1'b1;
            to_cnt_d = '0;
            lock_d   = 1'b0;
            rr_ptr_d = next_ptr;
            state_d  = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`endif
        end
      end
      S_SEND: begin
        ws_cnt_d = 1'b0;
        state_d  = S_WAIT_START;
      end
      S_WAIT_START: begin
        // Second cycle here moves on even if the busy rising edge was missed.
        if (bus.tx_busy || ws_cnt_q) state_d = S_WAIT_DONE;
        else                         ws_cnt_d = 1'b1;
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q) begin
            lock_d   = 1'b0;
            rr_ptr_d = next_ptr;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_LOCK;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      lock_q   <= 1'b0;
      last_q   <= 1'b0;
      send_q   <= 1'b0;
      ws_cnt_q <= 1'b0;
      data_q   <= '0;
`ifdef TX_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      last_q   <= last_d;
      send_q   <= send_d;
      ws_cnt_q <= ws_cnt_d;
      data_q   <= data_d;
`ifdef TX_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
`endif
    end
  end

  assign bus.req_ready   = ready;
  assign bus.tx_data     = data_q;
  assign bus.tx_send     = send_q;
  assign bus.grant_ch    = grant_q;
  assign bus.lock_active = lock_q;
`ifdef TX_ARB_TIMEOUT_EN
  assign bus.timeout_err = to_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scripted byte sources, a 4-cycle uart_tx
// busy model and a log of every issued byte with its owning channel.
module tb_uart_tx_arbiter;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int TO_CYC = 100;
  localparam int BUSY_CYC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_busy = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Byte sources: entries [0..len) of mem after base are offered in order.
  logic [7:0] mem   [NUM_CH][64];
  logic       lastm [NUM_CH][64];
  int         acc_cnt [NUM_CH];
  int         base    [NUM_CH];
  int         len     [NUM_CH];
  logic [NUM_CH-1:0]        src_valid, src_last;
  logic [NUM_CH*DATA_W-1:0] src_data;

  always_comb begin
    src_valid = '0;
    src_last  = '0;
    src_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc_cnt[i] - base[i] < len[i]) begin
        src_valid[i]         = 1'b1;
        src_data[i*8 +: 8]   = mem[i][(acc_cnt[i] - base[i]) & 63];
        src_last[i]          = lastm[i][(acc_cnt[i] - base[i]) & 63];
      end
    end
  end

  assign bus.req_valid = src_valid;
  assign bus.req_data  = src_data;
  assign bus.req_last  = src_last;

  always @(posedge clk)
    for (int i = 0; i < NUM_CH; i++)
      if (bus.req_ready[i]) acc_cnt[i] <= acc_cnt[i] + 1;

  int busy_cnt = 0;
  always @(posedge clk) begin
    if (rst)                 busy_cnt <= 0;
    else if (bus.tx_send)    busy_cnt <= BUSY_CYC;
    else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0) || force_busy;

  int log_ch[$];
  int log_d[$];
  always @(posedge clk)
    if (!rst && bus.tx_send) begin
      log_ch.push_back(int'(bus.grant_ch));
      log_d.push_back(int'(bus.tx_data));
    end

  task automatic set_src(input int ch, input int n);
    base[ch] = acc_cnt[ch];
    len[ch]  = n;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NUM_CH; i++) set_src(i, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_srcs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int max, output bit ok);
    bit done;
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      done = !bus.lock_active && !bus.tx_busy;
      for (int i = 0; i < NUM_CH; i++)
        if (acc_cnt[i] - base[i] < len[i]) done = 1'b0;
      if (done) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 6;
    if (bus.tx_data !== 8'h00)   begin failures++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
    if (bus.tx_send !== 1'b0)    begin failures++; $display("FAIL reset_tx_send got=%b exp=0", bus.tx_send); end
    if (bus.grant_ch !== 2'd0)   begin failures++; $display("FAIL reset_grant got=%0d exp=0", bus.grant_ch); end
    if (bus.lock_active !== 1'b0) begin failures++; $display("FAIL reset_lock got=%b exp=0", bus.lock_active); end
    if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", bus.timeout_err); end
    if (bus.req_ready !== 4'b0)  begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
  endtask

  task automatic test_single_byte();
    bit ok;
    int lb;
    lb = log_d.size();
    mem[0][0] = 8'h05; lastm[0][0] = 1'b1;
    set_src(0, 1);
    @(negedge clk);
    checks += 3;
    if (bus.lock_active !== 1'b1) begin failures++; $display("FAIL single_lock got=%b exp=1", bus.lock_active); end
    if (bus.grant_ch !== 2'd0)    begin failures++; $display("FAIL single_grant got=%0d exp=0", bus.grant_ch); end
    if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
    @(negedge clk);
    checks += 2;
    if (bus.tx_send !== 1'b1)   begin failures++; $display("FAIL single_send got=%b exp=1", bus.tx_send); end
    if (bus.tx_data !== 8'h05)  begin failures++; $display("FAIL single_data got=%h exp=05", bus.tx_data); end
    @(negedge clk);
    checks++;
    if (bus.tx_send !== 1'b0)   begin failures++; $display("FAIL single_send_pulse got=%b exp=0", bus.tx_send); end
    wait_drain(50, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL single_drain got=timeout exp=release"); end
    if (log_d.size() - lb != 1) begin failures++; $display("FAIL single_send_count got=%0d exp=1", log_d.size() - lb); end
  endtask

  // rr_ptr should sit at 1 after ch0's packet, so ch1 wins a tie with ch0.
  task automatic test_rr_pointer();
    bit ok;
    int lb;
    lb = log_d.size();
    mem[0][0] = 8'hA1; lastm[0][0] = 1'b1;
    mem[1][0] = 8'hB1; lastm[1][0] = 1'b1;
    set_src(0, 1);
    set_src(1, 1);
    wait_drain(100, ok);
    checks++;
    if (!ok || log_d.size() - lb != 2) begin
      failures++; $display("FAIL rr_ptr_drain got=%0d exp=2 bytes", log_d.size() - lb);
    end else begin
      checks += 2;
      if (log_ch[lb] != 1 || log_d[lb] != 8'hB1)
        begin failures++; $display("FAIL rr_ptr_first got=ch%0d/%h exp=ch1/b1", log_ch[lb], log_d[lb]); end
      if (log_ch[lb+1] != 0 || log_d[lb+1] != 8'hA1)
        begin failures++; $display("FAIL rr_ptr_second got=ch%0d/%h exp=ch0/a1", log_ch[lb+1], log_d[lb+1]); end
    end
  endtask

  task automatic test_packet_integrity();
    bit ok;
    int lb;
    lb = log_d.size();
    for (int k = 0; k < 40; k++) begin
      mem[1][k]   = 8'(k);
      lastm[1][k] = (k == 39);
    end
    mem[0][0] = 8'hC0; lastm[0][0] = 1'b1;
    set_src(1, 40);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (acc_cnt[1] - base[1] >= 3) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL integrity_start got=timeout exp=3 bytes"); end
    set_src(0, 1);
    wait_drain(2000, ok);
    checks++;
    if (!ok || log_d.size() - lb != 41) begin
      failures++; $display("FAIL integrity_count got=%0d exp=41", log_d.size() - lb);
    end else begin
      for (int k = 0; k < 40; k++) begin
        checks++;
        if (log_ch[lb+k] != 1 || log_d[lb+k] != k)
          begin failures++; $display("FAIL integrity_byte%0d got=ch%0d/%h exp=ch1/%h", k, log_ch[lb+k], log_d[lb+k], k); end
      end
      checks++;
      if (log_ch[lb+40] != 0 || log_d[lb+40] != 8'hC0)
        begin failures++; $display("FAIL integrity_next got=ch%0d/%h exp=ch0/c0", log_ch[lb+40], log_d[lb+40]); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int lb;
    int exp_ch [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1};
    int exp_d  [12] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31,
                        8'h02, 8'h03, 8'h12, 8'h13};
    apply_reset();
    lb = log_d.size();
    for (int i = 0; i < NUM_CH; i++)
      for (int k = 0; k < 4; k++) begin
        mem[i][k]   = 8'(i*16 + k);
        lastm[i][k] = (k % 2 == 1);
      end
    set_src(0, 4); set_src(1, 4); set_src(2, 2); set_src(3, 2);
    wait_drain(500, ok);
    checks++;
    if (!ok || log_d.size() - lb != 12) begin
      failures++; $display("FAIL rr_count got=%0d exp=12", log_d.size() - lb);
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (log_ch[lb+k] != exp_ch[k] || log_d[lb+k] != exp_d[k])
          begin failures++; $display("FAIL rr_seq%0d got=ch%0d/%h exp=ch%0d/%h", k, log_ch[lb+k], log_d[lb+k], exp_ch[k], exp_d[k]); end
      end
    end
  endtask

  task automatic test_busy_preasserted();
    bit ok;
    int bad;
    mem[2][0] = 8'h3C; lastm[2][0] = 1'b1;
    force_busy = 1'b1;
    set_src(2, 1);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.req_ready !== 4'b0 || bus.lock_active !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL busy_hold got=%0d bad cycles exp=0", bad); end
    force_busy = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL busy_release_ready got=%b exp=0100", bus.req_ready); end
    @(negedge clk);
    checks += 2;
    if (bus.tx_send !== 1'b1)  begin failures++; $display("FAIL busy_send got=%b exp=1", bus.tx_send); end
    if (bus.tx_data !== 8'h3C) begin failures++; $display("FAIL busy_data got=%h exp=3c", bus.tx_data); end
    wait_drain(50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL busy_drain got=timeout exp=release"); end
  endtask

  task automatic test_timeout();
    bit ok;
    int lb;
    int at;
    lb = log_d.size();
    mem[2][0] = 8'h11; lastm[2][0] = 1'b0;
    mem[3][0] = 8'h33; lastm[3][0] = 1'b1;
    set_src(2, 1);
    @(negedge clk);
    checks++;
    if (bus.grant_ch !== 2'd2 || bus.lock_active !== 1'b1)
      begin failures++; $display("FAIL to_grant got=ch%0d lock=%b exp=ch2 lock=1", bus.grant_ch, bus.lock_active); end
    set_src(3, 1);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.tx_busy) begin ok = 1'b1; break; end end
    if (ok) begin
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin @(negedge clk); if (!bus.tx_busy) begin ok = 1'b1; break; end end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL to_first_byte got=timeout exp=busy cycle"); end
`ifdef TX_ARB_TIMEOUT_EN
    at = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.timeout_err) begin at = k; break; end
    end
    checks += 2;
    if (at != TO_CYC + 1) begin failures++; $display("FAIL to_pulse_time got=%0d exp=%0d", at, TO_CYC + 1); end
    if (bus.lock_active !== 1'b0) begin failures++; $display("FAIL to_release got=%b exp=0", bus.lock_active); end
    @(negedge clk);
    checks += 2;
    if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL to_pulse_width got=%b exp=0", bus.timeout_err); end
    if (bus.grant_ch !== 2'd3 || bus.lock_active !== 1'b1)
      begin failures++; $display("FAIL to_next_grant got=ch%0d lock=%b exp=ch3 lock=1", bus.grant_ch, bus.lock_active); end
    wait_drain(50, ok);
    checks++;
    if (!ok || log_d.size() - lb != 2 || log_ch[log_ch.size()-1] != 3)
      begin failures++; $display("FAIL to_ch3_send got=%0d bytes exp=2 ending ch3", log_d.size() - lb); end
`else
    at = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.timeout_err || !bus.lock_active) at++;
    end
    checks += 2;
    if (at != 0) begin failures++; $display("FAIL hold_lock got=%0d dropped cycles exp=0", at); end
    if (bus.grant_ch !== 2'd2 || log_d.size() - lb != 1)
      begin failures++; $display("FAIL hold_owner got=ch%0d/%0d bytes exp=ch2/1", bus.grant_ch, log_d.size() - lb); end
`endif
  endtask

  task automatic test_reset_midpacket();
    bit ok;
    int lb;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      mem[1][k]   = 8'(8'h50 + k);
      lastm[1][k] = (k == 4);
    end
    set_src(1, 5);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (acc_cnt[1] - base[1] >= 2) begin ok = 1'b1; break; end
    end
    if (ok) begin
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin @(negedge clk); if (bus.tx_busy) begin ok = 1'b1; break; end end
    end
    @(negedge clk);
    checks++;
    if (!ok) begin failures++; $display("FAIL midpkt_reach got=timeout exp=byte2 busy"); end
    rst = 1'b1;
    clear_srcs();
    @(negedge clk);
    checks += 6;
    if (bus.tx_data !== 8'h00)    begin failures++; $display("FAIL midpkt_tx_data got=%h exp=00", bus.tx_data); end
    if (bus.tx_send !== 1'b0)     begin failures++; $display("FAIL midpkt_tx_send got=%b exp=0", bus.tx_send); end
    if (bus.grant_ch !== 2'd0)    begin failures++; $display("FAIL midpkt_grant got=%0d exp=0", bus.grant_ch); end
    if (bus.lock_active !== 1'b0) begin failures++; $display("FAIL midpkt_lock got=%b exp=0", bus.lock_active); end
    if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL midpkt_timeout_err got=%b exp=0", bus.timeout_err); end
    if (bus.req_ready !== 4'b0)   begin failures++; $display("FAIL midpkt_ready got=%b exp=0000", bus.req_ready); end
    rst = 1'b0;
    lb = log_d.size();
    for (int k = 0; k < 30; k++) @(negedge clk);
    checks++;
    if (log_d.size() != lb || bus.lock_active !== 1'b0)
      begin failures++; $display("FAIL midpkt_quiet got=%0d sends exp=0", log_d.size() - lb); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_rr_pointer();
    test_packet_integrity();
    test_round_robin();
    test_busy_preasserted();
    test_timeout();
    test_reset_midpacket();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
